sp_ram_be_pmt: RTL and testbench

Parametrised single-port synchronous RAM. Successor to the fixed 32-entry single-port array, generalised in width and depth. Adds:
- per-lane write enables
- selectable read-during-write mode
- optional output register stage
- a post-reset clear sequencer that zero-fills the array
Used as a generic local buffer / coefficient store behind datapath blocks running on wclk.

---
 rtl/sp_ram_pkg.sv | 30 +++
 rtl/sp_ram_be_pmt_if.sv | 41 ++++
 rtl/sp_ram_clr_seq.sv | 49 ++++
 rtl/sp_ram_be_pmt.sv | 180 ++++++++++++++++++
 tb/tb_sp_ram_be_pmt.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/sp_ram_pkg.sv
// rtl/sp_ram_pkg.sv - shared types and helpers for the byte-enable single-port RAM
package sp_ram_pkg;

  typedef enum logic [1:0] {
    READ_FIRST  = 2'd0,
    WRITE_FIRST = 2'd1,
    NO_CHANGE   = 2'd2
  } rdw_mode_e;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int unsigned MAX_LW = 64;

  function automatic int unsigned lane_cnt(input int unsigned dw, input int unsigned lw);
    return dw / lw;
  endfunction

  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Zero-extension to MAX_LW leaves the parity of a narrower lane unchanged.
  function automatic logic lane_parity(input logic [MAX_LW-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sp_ram_be_pmt_if.sv
// rtl/sp_ram_be_pmt_if.sv - request/response bundle for sp_ram_be_pmt
// perr exists only when SP_RAM_PARITY_EN is defined.
interface sp_ram_be_pmt_if #(
  parameter int unsigned DW    = 16,
  parameter int unsigned LW    = 8,
  parameter int unsigned DEPTH = 32
);
  import sp_ram_pkg::*;

  localparam int unsigned NL = lane_cnt(DW, LW);
  localparam int unsigned AW = addr_w(DEPTH);

  logic          en;
  logic          we;
  logic [NL-1:0] be;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          rvalid;
  logic          busy;
`ifdef SP_RAM_PARITY_EN
  logic [NL-1:0] perr;
`endif

  modport master (
    output en, we, be, addr, din,
`ifdef SP_RAM_PARITY_EN
    input  perr,
`endif
    input  dout, rvalid, busy
  );

  modport slave (
    input  en, we, be, addr, din,
`ifdef SP_RAM_PARITY_EN
    output perr,
`endif
    output dout, rvalid, busy
  );

endinterface

// File: rtl/sp_ram_clr_seq.sv
// rtl/sp_ram_clr_seq.sv - post-reset zero-fill sequencer (CLEAR -> READY)
module sp_ram_clr_seq
  import sp_ram_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  localparam int unsigned AW   = addr_w(DEPTH)
) (
  input  logic          wclk,
  input  logic          rst_n,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == LAST) state_d = READY;
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    busy     = (state_q == CLEAR);
    clr_we   = (state_q == CLEAR);
    clr_addr = cnt_q;
  end

endmodule

// File: rtl/sp_ram_be_pmt.sv
// rtl/sp_ram_be_pmt.sv - single-port RAM with lane enables, RDW modes, optional output reg
// Optional per-lane parity storage and checking under SP_RAM_PARITY_EN.
module sp_ram_be_pmt
  import sp_ram_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned LW    = 8,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned RDW   = 0,
  parameter int unsigned OREG  = 0
) (
  input  logic          wclk,
  input  logic          rst_n,
  sp_ram_be_pmt_if.slave bus
);

  localparam int unsigned NL   = lane_cnt(DW, LW);
  localparam int unsigned AW   = addr_w(DEPTH);
  localparam rdw_mode_e   MODE = rdw_mode_e'(2'(RDW));

  logic          busy, clr_we, acc, in_range, wr_en;
  logic [AW-1:0] clr_addr, wr_addr;
  logic [NL-1:0] wr_be;
  logic [DW-1:0] wr_data, old_word, new_word, rd_word;
  logic          upd1, val1, rvalid1, rvalid_q;
  logic [DW-1:0] dout1, dout_q;

  logic [DW-1:0] mem [DEPTH];

  sp_ram_clr_seq #(.DEPTH(DEPTH)) u_clr_seq (
    .wclk     (wclk),
    .rst_n    (rst_n),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Clear sequencer owns the write port while busy; user requests are dropped.
  always_comb begin
    acc      = bus.en & ~busy;
    in_range = (32'(bus.addr) < DEPTH);
    if (busy) begin
      wr_en   = clr_we;
      wr_addr = clr_addr;
      wr_be   = '1;
      wr_data = '0;
    end else begin
      wr_en   = acc & bus.we & in_range;
      wr_addr = bus.addr;
      wr_be   = bus.be;
      wr_data = bus.din;
    end
  end

  always_ff @(posedge wclk) begin
    if (wr_en) begin
      for (int k = 0; k < NL; k++) begin
        if (wr_be[k]) mem[wr_addr][k*LW +: LW] <= wr_data[k*LW +: LW];
      end
    end
  end

  always_comb begin
    old_word = in_range ? mem[bus.addr] : '0;
    new_word = old_word;
    for (int k = 0; k < NL; k++) begin
      if (bus.be[k]) new_word[k*LW +: LW] = bus.din[k*LW +: LW];
    end
  end

  always_comb begin
    upd1    = 1'b0;
    val1    = 1'b0;
    rd_word = old_word;
    if (acc) begin
      if (!bus.we) begin
        upd1 = 1'b1;
        val1 = 1'b1;
      end else begin
        case (MODE)
          READ_FIRST: begin
            upd1 = 1'b1;
            val1 = 1'b1;
          end
          WRITE_FIRST: begin
            upd1    = 1'b1;
            val1    = 1'b1;
            rd_word = in_range ? new_word : '0;
          end
          default: begin
            upd1 = 1'b0;
            val1 = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      dout1   <= '0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid1 <= val1;
      if (upd1) dout1 <= rd_word;
    end
  end

`ifdef SP_RAM_PARITY_EN
  logic [NL-1:0] pmem [DEPTH];
  logic [NL-1:0] wr_par, old_par, new_par, rd_par, perr_c, perr1, perr_q;

  always_comb begin
    for (int k = 0; k < NL; k++) wr_par[k] = lane_parity(MAX_LW'(wr_data[k*LW +: LW]));
  end

  always_ff @(posedge wclk) begin
    if (wr_en) begin
      for (int k = 0; k < NL; k++) begin
        if (wr_be[k]) pmem[wr_addr][k] <= wr_par[k];
      end
    end
  end

  // Parity follows the same source selection as the data word it travels with.
  always_comb begin
    old_par = in_range ? pmem[bus.addr] : '0;
    new_par = old_par;
    for (int k = 0; k < NL; k++) begin
      if (bus.be[k]) new_par[k] = lane_parity(MAX_LW'(bus.din[k*LW +: LW]));
    end
    rd_par = old_par;
    if (acc && bus.we && MODE == WRITE_FIRST) rd_par = in_range ? new_par : '0;
    for (int k = 0; k < NL; k++) perr_c[k] = lane_parity(MAX_LW'(rd_word[k*LW +: LW])) ^ rd_par[k];
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) perr1 <= '0;
    else if (upd1) perr1 <= perr_c;
  end
`endif

  if (OREG != 0) begin : g_oreg
    logic [DW-1:0] dout2;
    logic          rvalid2;
    always_ff @(posedge wclk or negedge rst_n) begin
      if (!rst_n) begin
        dout2   <= '0;
        rvalid2 <= 1'b0;
      end else begin
        rvalid2 <= rvalid1;
        if (rvalid1) dout2 <= dout1;
      end
    end
    assign dout_q   = dout2;
    assign rvalid_q = rvalid2;
`ifdef SP_RAM_PARITY_EN
    logic [NL-1:0] perr2;
    always_ff @(posedge wclk or negedge rst_n) begin
      if (!rst_n) perr2 <= '0;
      else if (rvalid1) perr2 <= perr1;
    end
    assign perr_q = perr2;
`endif
  end else begin : g_noreg
    assign dout_q   = dout1;
    assign rvalid_q = rvalid1;
`ifdef SP_RAM_PARITY_EN
    assign perr_q = perr1;
`endif
  end

  assign bus.dout   = dout_q;
  assign bus.rvalid = rvalid_q;
  assign bus.busy   = busy;
`ifdef SP_RAM_PARITY_EN
  assign bus.perr   = rvalid_q ? perr_q : '0;
`endif

endmodule

// File: tb/tb_sp_ram_be_pmt.sv
// tb/tb_sp_ram_be_pmt.sv - directed bench over five configurations sharing one stimulus
// Parity checks compile only when SP_RAM_PARITY_EN is defined.
module tb_sp_ram_be_pmt;

  logic        wclk  = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic        we    = 1'b0;
  logic [1:0]  be    = 2'b00;
  logic [4:0]  addr  = 5'd0;
  logic [15:0] din   = 16'h0;
  int          errors = 0;
  int          checks = 0;
  int          n_a, n_e, rv;

  always #5 wclk = ~wclk;

  // a: READ_FIRST, b: WRITE_FIRST, c: NO_CHANGE, d: OREG=1, e: DEPTH=20
  sp_ram_be_pmt_if #(.DW(16), .LW(8), .DEPTH(32)) i_a ();
  sp_ram_be_pmt_if #(.DW(16), .LW(8), .DEPTH(32)) i_b ();
  sp_ram_be_pmt_if #(.DW(16), .LW(8), .DEPTH(32)) i_c ();
  sp_ram_be_pmt_if #(.DW(16), .LW(8), .DEPTH(32)) i_d ();
  sp_ram_be_pmt_if #(.DW(16), .LW(8), .DEPTH(20)) i_e ();

  assign {i_a.en, i_a.we, i_a.be, i_a.addr, i_a.din} = {en, we, be, addr, din};
  assign {i_b.en, i_b.we, i_b.be, i_b.addr, i_b.din} = {en, we, be, addr, din};
  assign {i_c.en, i_c.we, i_c.be, i_c.addr, i_c.din} = {en, we, be, addr, din};
  assign {i_d.en, i_d.we, i_d.be, i_d.addr, i_d.din} = {en, we, be, addr, din};
  assign {i_e.en, i_e.we, i_e.be, i_e.addr, i_e.din} = {en, we, be, addr, din};

  sp_ram_be_pmt #(.DW(16), .LW(8), .DEPTH(32), .RDW(0), .OREG(0)) u_a (.wclk(wclk), .rst_n(rst_n), .bus(i_a));
  sp_ram_be_pmt #(.DW(16), .LW(8), .DEPTH(32), .RDW(1), .OREG(0)) u_b (.wclk(wclk), .rst_n(rst_n), .bus(i_b));
  sp_ram_be_pmt #(.DW(16), .LW(8), .DEPTH(32), .RDW(2), .OREG(0)) u_c (.wclk(wclk), .rst_n(rst_n), .bus(i_c));
  sp_ram_be_pmt #(.DW(16), .LW(8), .DEPTH(32), .RDW(0), .OREG(1)) u_d (.wclk(wclk), .rst_n(rst_n), .bus(i_d));
  sp_ram_be_pmt #(.DW(16), .LW(8), .DEPTH(20), .RDW(0), .OREG(0)) u_e (.wclk(wclk), .rst_n(rst_n), .bus(i_e));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0;
    we = 1'b0;
    be = 2'b00;
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d, input logic [1:0] b);
    en = 1'b1; we = 1'b1; addr = a; din = d; be = b;
    step();
  endtask

  task automatic rd(input logic [4:0] a);
    en = 1'b1; we = 1'b0; addr = a;
    step();
  endtask

  // Counts edges after release until busy drops, bounded at 100 cycles.
  task automatic wait_clear();
    n_a = 0; n_e = 0; rv = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (i_a.rvalid) rv++;
      if (!i_e.busy && n_e == 0) n_e = i;
      if (!i_a.busy) begin
        n_a = i;
        break;
      end
    end
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      rd(5'(i));
      check(tag, {15'b0, i_a.rvalid, i_a.dout}, {15'b0, 1'b1, 16'h0000});
    end
    idle();
  endtask

  initial begin
    step();
    step();
    check("reset_a", {14'b0, i_a.busy, i_a.rvalid, i_a.dout}, {14'b0, 1'b1, 1'b0, 16'h0000});
    check("reset_d", {14'b0, i_d.busy, i_d.rvalid, i_d.dout}, {14'b0, 1'b1, 1'b0, 16'h0000});

    // Early read held through the whole clear must be dropped.
    en = 1'b1; we = 1'b0; addr = 5'd5;
    rst_n = 1'b1;
    wait_clear();
    idle();
    check("clear_len_32", n_a, 32);
    check("clear_len_20", n_e, 20);
    check("clear_drop_read", rv, 0);
    read_all_zero("clear_zero");

    // Lane writes
    wr(5'd3, 16'hA55A, 2'b11);
    wr(5'd3, 16'h1234, 2'b01);
    check("lane_wf_merge", {15'b0, i_b.rvalid, i_b.dout}, {15'b0, 1'b1, 16'hA534});
    check("lane_rf_old", {15'b0, i_a.rvalid, i_a.dout}, {15'b0, 1'b1, 16'hA55A});
    rd(5'd3);
    check("lane_read", {15'b0, i_a.rvalid, i_a.dout}, {15'b0, 1'b1, 16'hA534});
    check("oreg_lag", {15'b0, i_d.rvalid, i_d.dout}, {15'b0, 1'b1, 16'hA55A});
    idle();
    step();
    check("lane_hold", {15'b0, i_a.rvalid, i_a.dout}, {15'b0, 1'b0, 16'hA534});
    check("oreg_read", {15'b0, i_d.rvalid, i_d.dout}, {15'b0, 1'b1, 16'hA534});
    step();
    check("oreg_pulse", {15'b0, i_d.rvalid, i_d.dout}, {15'b0, 1'b0, 16'hA534});

    // Read-during-write modes
    wr(5'd7, 16'h00FF, 2'b11);
    wr(5'd7, 16'hBEEF, 2'b10);
    check("rdw_read_first", {15'b0, i_a.rvalid, i_a.dout}, {15'b0, 1'b1, 16'h00FF});
    check("rdw_write_first", {15'b0, i_b.rvalid, i_b.dout}, {15'b0, 1'b1, 16'hBEFF});
    check("rdw_no_change", {15'b0, i_c.rvalid, i_c.dout}, {15'b0, 1'b0, 16'hA534});
    rd(5'd7);
    check("rdw_after_rf", {15'b0, i_a.rvalid, i_a.dout}, {15'b0, 1'b1, 16'hBEFF});
    check("rdw_after_nc", {15'b0, i_c.rvalid, i_c.dout}, {15'b0, 1'b1, 16'hBEFF});

    // Out of range on DEPTH=20; same address is legal on DEPTH=32
    wr(5'd25, 16'h1111, 2'b11);
    rd(5'd25);
    check("oor_read", {15'b0, i_e.rvalid, i_e.dout}, {15'b0, 1'b1, 16'h0000});
    check("inrange_25", {15'b0, i_a.rvalid, i_a.dout}, {15'b0, 1'b1, 16'h1111});
    rd(5'd19);
    check("oor_top_word", {15'b0, i_e.rvalid, i_e.dout}, {15'b0, 1'b1, 16'h0000});
    rd(5'd5);
    check("oor_no_alias", {15'b0, i_e.rvalid, i_e.dout}, {15'b0, 1'b1, 16'h0000});
    idle();

    // Mid-clear reset, with stale data seeded at both ends of the array
    wr(5'd0, 16'hFFFF, 2'b11);
    wr(5'd31, 16'h5A5A, 2'b11);
    rd(5'd31);
    check("seed_read", {15'b0, i_a.rvalid, i_a.dout}, {15'b0, 1'b1, 16'h5A5A});
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {14'b0, i_a.busy, i_a.rvalid, i_a.dout}, {14'b0, 1'b1, 1'b0, 16'h0000});
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    rst_n = 1'b0;
    #1;
    check("midclear_busy", {14'b0, i_a.busy, i_a.rvalid, i_a.dout}, {14'b0, 1'b1, 1'b0, 16'h0000});
    step();
    step();
    rst_n = 1'b1;
    wait_clear();
    check("reclear_len", n_a, 32);
    read_all_zero("reclear_zero");

`ifdef SP_RAM_PARITY_EN
    wr(5'd9, 16'h0301, 2'b11);
    idle();
    step();
    force u_a.mem[9] = 16'h0300;
    rd(5'd9);
    check("perr_flip", {14'b0, i_a.rvalid, i_a.perr}, {14'b0, 1'b1, 2'b01});
    release u_a.mem[9];
    rd(5'd3);
    check("perr_clean", {14'b0, i_a.rvalid, i_a.perr}, {14'b0, 1'b1, 2'b00});
    idle();
    step();
    check("perr_idle", {14'b0, i_a.rvalid, i_a.perr}, {14'b0, 1'b0, 2'b00});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
